spi_master_xfer_scheduler: RTL

//  Upstream word scheduler for spi_module_master. Buffers outgoing words in a TX FIFO.

---
 rtl/spi_master_xfer_scheduler.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/spi_master_xfer_scheduler.sv
// Word scheduler in front of spi_module_master: TX/RX FIFOs, one master
// transaction per word, programmable CS-high gap between words.
module spi_master_xfer_scheduler #(
   parameter int PAYLOAD_BITS = 8,
   parameter int FIFO_DEPTH   = 8,
   parameter int GAP_CYCLES   = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        enable,
   input  logic                        clear,
   input  logic [PAYLOAD_BITS-1:0]     tx_data,
   input  logic                        tx_valid,
   output logic                        tx_ready,
   output logic [PAYLOAD_BITS-1:0]     rx_data,
   output logic                        rx_valid,
   input  logic                        rx_ready,
   output logic                        spi_en,
   output logic                        transmit_en,
   output logic [PAYLOAD_BITS-1:0]     spi_mosi_data,
   input  logic [PAYLOAD_BITS-1:0]     spi_miso_data,
   input  logic                        payload_done,
   output logic [$clog2(FIFO_DEPTH):0] tx_level,
   output logic [$clog2(FIFO_DEPTH):0] rx_level,
   output logic                        busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(GAP_CYCLES + 1);
   localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} state_t;

   state_t                  state, state_nxt;
   logic [CW-1:0]           gap_cnt;
   logic [PAYLOAD_BITS-1:0] tx_mem [FIFO_DEPTH];
   logic [PAYLOAD_BITS-1:0] rx_mem [FIFO_DEPTH];
   logic [AW-1:0]           tx_wr, tx_rd, rx_wr, rx_rd;
   logic                    flush, launch_ok, inflight;
   logic                    tx_push, tx_pop, rx_push, rx_pop;

   // RX space is reserved for the word in flight before another launch
   assign inflight  = (state == LAUNCH) || (state == WAIT);
   assign launch_ok = enable && (tx_level != '0) &&
                      (({1'b0, rx_level} + {{LW{1'b0}}, inflight}) < {1'b0, DEPTH_L});

   always_comb begin
      state_nxt   = state;
      transmit_en = 1'b0;
      flush       = 1'b0;
      case (state)
         IDLE: begin
            if (clear)
               flush = 1'b1;
            else if (launch_ok)
               state_nxt = LAUNCH;
         end
         LAUNCH: begin
            transmit_en = 1'b1;
            state_nxt   = WAIT;
         end
         WAIT: begin
            if (payload_done)
               state_nxt = GAP;
         end
         GAP: begin
            // last gap cycle decides like IDLE, so the next launch lands GAP_CYCLES+1 after payload_done
            if (gap_cnt == GAP_LAST)
               state_nxt = launch_ok ? LAUNCH : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy     = (state != IDLE);
   assign spi_en   = busy;
   assign tx_pop   = (state == LAUNCH);
   assign rx_push  = (state == WAIT) && payload_done;
   assign tx_ready = (tx_level != DEPTH_L);
   assign rx_valid = (rx_level != '0);
   assign tx_push  = tx_valid && tx_ready && !flush;
   assign rx_pop   = rx_valid && rx_ready && !flush;
   assign rx_data  = rx_valid ? rx_mem[rx_rd] : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         gap_cnt       <= '0;
         spi_mosi_data <= '0;
      end else begin
         state <= state_nxt;
         if (rx_push)
            gap_cnt <= '0;
         else if (state == GAP)
            gap_cnt <= gap_cnt + CW'(1);
         if (tx_pop)
            spi_mosi_data <= tx_mem[tx_rd];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_wr    <= '0;
         tx_rd    <= '0;
         tx_level <= '0;
      end else if (flush) begin
         tx_wr    <= '0;
         tx_rd    <= '0;
         tx_level <= '0;
      end else begin
         if (tx_push)
            tx_wr <= tx_wr + AW'(1);
         if (tx_pop)
            tx_rd <= tx_rd + AW'(1);
         if (tx_push && !tx_pop)
            tx_level <= tx_level + LW'(1);
         else if (!tx_push && tx_pop)
            tx_level <= tx_level - LW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_wr    <= '0;
         rx_rd    <= '0;
         rx_level <= '0;
      end else if (flush) begin
         rx_wr    <= '0;
         rx_rd    <= '0;
         rx_level <= '0;
      end else begin
         if (rx_push)
            rx_wr <= rx_wr + AW'(1);
         if (rx_pop)
            rx_rd <= rx_rd + AW'(1);
         if (rx_push && !rx_pop)
            rx_level <= rx_level + LW'(1);
         else if (!rx_push && rx_pop)
            rx_level <= rx_level - LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push)
         tx_mem[tx_wr] <= tx_data;
      if (rx_push)
         rx_mem[rx_wr] <= spi_miso_data;
   end

endmodule
